// File: rtl/btn_tx_queue.sv
// rtl/btn_tx_queue.sv - button-press byte queue feeding the UART transmitter
//
// Captures data_sw into a small circular FIFO on each debounced one_shot
// pulse. It drains the FIFO to the UART TX one byte per frame, using a
// tx_start / tx_busy handshake.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   one_shot  push request (one cycle per button press)
//   data_sw   switch byte captured on one_shot
//   tx_busy   UART TX frame in progress
//   tx_start  one-cycle start pulse to UART TX
//   tx_data   byte to transmit; held from one tx_start to the next
//   full      registered count==DEPTH
//   empty     registered count==0
//   drop_cnt  pushes lost while full, saturating at 255

module btn_tx_queue #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int ACK_TO = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              one_shot,
    input  logic [DATA_W-1:0] data_sw,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output logic              full,
    output logic              empty,
    output logic [7:0]        drop_cnt
);

    localparam int TO_W = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_ACK  = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                push;
    logic                pop;

    // Full comes from the registered flag, so a push while full is lost
    // even if the drain frees an entry on the same edge.
    assign push = one_shot & ~full_q;
    // The FSM only enters START with a non-empty FIFO, and only START
    // decrements count. So the pop here cannot underflow.
    assign pop  = (state_q == S_START);

    // FIFO bookkeeping
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase

        if (one_shot && full_q && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end

        full_d  = (count_d == (ADDR_W+1)'(DEPTH));
        empty_d = (count_d == '0);
    end

    // FSM next state
    always_comb begin
        state_d   = state_q;
        to_cnt_d  = to_cnt_q;
        tx_data_d = tx_data_q;

        case (state_q)
            S_IDLE: begin
                if (!empty_q && !tx_busy) begin
                    state_d   = S_START;
                    tx_data_d = mem_q[rd_ptr_q];
                end
            end
            S_START: begin
                state_d  = S_WAIT_ACK;
                to_cnt_d = '0;
            end
            S_WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (to_cnt_q == TO_W'(ACK_TO - 1)) begin
                    // UART never acknowledged; the byte counts as consumed.
                    state_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs (Moore)
    always_comb begin
        tx_start = (state_q == S_START);
    end

    assign tx_data  = tx_data_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign drop_cnt = drop_cnt_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            drop_cnt_q <= '0;
            to_cnt_q   <= '0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            drop_cnt_q <= drop_cnt_d;
            to_cnt_q   <= to_cnt_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Storage array; contents are meaningless after reset because the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_sw;
        end
    end

endmodule

// File: tb/tb_btn_tx_queue.sv
// tb/tb_btn_tx_queue.sv - randomized self-checking bench for btn_tx_queue

module tb_btn_tx_queue;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int ACK_TO = 16;

    logic              clk;
    logic              rst;
    logic              one_shot;
    logic [DATA_W-1:0] data_sw;
    logic              tx_busy;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              full;
    logic              empty;
    logic [7:0]        drop_cnt;

    btn_tx_queue #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(2),
        .ACK_TO(ACK_TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .one_shot(one_shot),
        .data_sw (data_sw),
        .tx_busy (tx_busy),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .full    (full),
        .empty   (empty),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks;
    int n_errors;
    int cyc;

    // Reference model: byte queue, drop counter, last transmitted byte.
    logic [7:0] mq[$];
    logic [7:0] sent[$];
    int         starts[$];
    int         exp_drop;
    logic [7:0] exp_tx;
    bit         prev_busy;
    bit         prev_start;

    // UART responder model
    bit uart_en;
    bit pend;
    int ack_cd;
    int busy_cd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_drop   = 0;
        exp_tx     = 8'h00;
        prev_busy  = 1'b0;
        prev_start = 1'b0;
        pend       = 1'b0;
    endtask

    // Called at a negedge with this cycle's inputs already driven.
    task automatic tick();
        bit start_seen;
        int sz;
        start_seen = tx_start;
        sz = mq.size();
        if (tx_start) begin
            check("start_has_data", 32'(mq.size() != 0), 1);
            check("start_after_idle_not_busy", 32'(prev_busy), 0);
            check("start_single_cycle", 32'(prev_start), 0);
            if (mq.size() != 0) exp_tx = mq.pop_front();
            sent.push_back(tx_data);
            starts.push_back(cyc);
        end
        check("tx_data", 32'(tx_data), 32'(exp_tx));
        if (one_shot) begin
            if (sz < DEPTH) mq.push_back(data_sw);
            else if (exp_drop < 255) exp_drop++;
        end
        prev_busy  = tx_busy;
        prev_start = tx_start;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check("full", 32'(full), 32'(mq.size() == DEPTH));
        check("empty", 32'(empty), 32'(mq.size() == 0));
        check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
        if (uart_en) begin
            if (start_seen) begin
                pend   = 1'b1;
                ack_cd = $urandom_range(0, 2);
            end
            if (pend) begin
                if (ack_cd == 0) begin
                    tx_busy = 1'b1;
                    pend    = 1'b0;
                    busy_cd = $urandom_range(2, 6);
                end else begin
                    ack_cd--;
                end
            end else if (tx_busy) begin
                if (busy_cd <= 1) tx_busy = 1'b0;
                else busy_cd--;
            end
        end
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (k < budget && !(mq.size() == 0 && !tx_busy && !pend)) begin
            tick();
            k++;
        end
        check("drain_done", mq.size(), 0);
        repeat (24) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n0;
        int d0;
        bit hit;
        int s0;
        int s1;

        clk = 1'b0; rst = 1'b1; one_shot = 1'b0; data_sw = '0; tx_busy = 1'b0;
        uart_en = 1'b0; ack_cd = 0; busy_cd = 0;
        n_checks = 0; n_errors = 0; cyc = 0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_full", 32'(full), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_drop", 32'(drop_cnt), 0);
        rst = 1'b0;

        // 1: single press, start two cycles later
        data_sw = 8'hA5; one_shot = 1'b1;
        tick();
        one_shot = 1'b0;
        check("t1_no_start_n1", 32'(tx_start), 0);
        tick();
        check("t1_start_n2", 32'(tx_start), 1);
        check("t1_data_n2", 32'(tx_data), 32'hA5);
        tick();
        check("t1_empty_again", 32'(empty), 1);
        repeat (22) tick();

        // 2: fill while busy, fifth press dropped, drain in order
        tx_busy = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            data_sw = 8'(i); one_shot = 1'b1;
            tick();
            if (i == 4) check("t2_full_after4", 32'(full), 1);
        end
        one_shot = 1'b0;
        check("t2_drop1", 32'(drop_cnt), 1);
        sent.delete();
        tx_busy = 1'b0; uart_en = 1'b1; pend = 1'b0;
        drain(400);
        check("t2_sent_count", sent.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < sent.size()) check("t2_sent_order", 32'(sent[i]), 32'(i + 1));
        end

        // 3: full, press coincident with pop is dropped
        uart_en = 1'b0; tx_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_sw = 8'h10 + 8'(i); one_shot = 1'b1;
            tick();
        end
        one_shot = 1'b0;
        check("t3_full", 32'(full), 1);
        tx_busy = 1'b0;
        hit = 1'b0;
        d0 = exp_drop;
        for (int k = 0; k < 10; k++) begin
            if (tx_start) begin
                one_shot = 1'b1; data_sw = 8'hEE;
                tick();
                one_shot = 1'b0;
                hit = 1'b1;
                break;
            end
            tick();
        end
        check("t3_saw_start", 32'(hit), 1);
        check("t3_drop_inc", 32'(drop_cnt), 32'(d0 + 1));
        check("t3_not_full", 32'(full), 0);
        check("t3_not_empty", 32'(empty), 0);
        uart_en = 1'b1; pend = 1'b0;
        drain(400);

        // 4: tx_busy never rises, ack timeout then next byte
        uart_en = 1'b0; tx_busy = 1'b0;
        starts.delete();
        n0 = cyc;
        data_sw = 8'h41; one_shot = 1'b1; tick();
        data_sw = 8'h42; tick();
        one_shot = 1'b0;
        repeat (60) tick();
        check("t4_start_count", starts.size(), 2);
        s0 = (starts.size() > 0) ? starts[0] : -1;
        s1 = (starts.size() > 1) ? starts[1] : -1;
        check("t4_first_latency", 32'(s0 - n0), 2);
        check("t4_timeout_gap", 32'(s1 - s0), 32'(ACK_TO + 2));

        // Random traffic against a responding UART
        uart_en = 1'b1; pend = 1'b0; tx_busy = 1'b0;
        for (int k = 0; k < 600; k++) begin
            one_shot = ($urandom_range(0, 3) == 0);
            data_sw  = 8'($urandom);
            tick();
        end
        one_shot = 1'b0;
        drain(600);

        // 5: reset during WAIT_DONE with three bytes queued
        uart_en = 1'b0; tx_busy = 1'b0;
        data_sw = 8'h5A; one_shot = 1'b1; tick();
        one_shot = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (tx_start) break;
            tick();
        end
        tx_busy = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            data_sw = 8'hC0 + 8'(i); one_shot = 1'b1;
            tick();
        end
        one_shot = 1'b0;
        check("t5_pre_not_empty", 32'(empty), 0);
        check("t5_pre_tx_data", 32'(tx_data), 32'h5A);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_tx_start", 32'(tx_start), 0);
        check("t5_rst_tx_data", 32'(tx_data), 0);
        check("t5_rst_empty", 32'(empty), 1);
        check("t5_rst_full", 32'(full), 0);
        check("t5_rst_drop", 32'(drop_cnt), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0; tx_busy = 1'b0;
        starts.delete();
        repeat (30) tick();
        check("t5_no_start_after", starts.size(), 0);

        // 6: drop counter saturation
        tx_busy = 1'b1;
        for (int k = 0; k < DEPTH + 300; k++) begin
            data_sw = 8'($urandom); one_shot = 1'b1;
            tick();
        end
        one_shot = 1'b0;
        check("t6_drop_sat", 32'(drop_cnt), 255);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
